// File: rtl/fp32_to_bf16_cvt.sv
// FP32 to BF16 narrowing converter with round-to-nearest-even and IEEE exception flags.
// One register stage between operand_a and all outputs.
module fp32_to_bf16_cvt (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] operand_a,
    output logic [15:0] result,
    output logic        invalid,
    output logic        overflow,
    output logic        underflow,
    output logic        inexact
);

    logic        w_s;
    logic [7:0]  w_e;
    logic [22:0] w_m;
    logic [15:0] w_upper;
    logic [15:0] w_lower;
    logic        w_is_nan;
    logic        w_is_inf;
    logic        w_is_zero;
    logic        w_round_up;
    logic [15:0] w_rounded;

    logic [15:0] w_result;
    logic        w_invalid;
    logic        w_overflow;
    logic        w_underflow;
    logic        w_inexact;

    logic [15:0] r_result;
    logic        r_invalid;
    logic        r_overflow;
    logic        r_underflow;
    logic        r_inexact;

    assign w_s       = operand_a[31];
    assign w_e       = operand_a[30:23];
    assign w_m       = operand_a[22:0];
    assign w_upper   = operand_a[31:16];
    assign w_lower   = operand_a[15:0];

    assign w_is_nan  = (w_e == 8'hFF) && (w_m != 23'd0);
    assign w_is_inf  = (w_e == 8'hFF) && (w_m == 23'd0);
    assign w_is_zero = (w_e == 8'h00) && (w_m == 23'd0);

    // Ties go to even: only round up on an exact half when the kept LSB is odd.
    assign w_round_up = w_lower[15] & ((w_lower[14:0] != 15'd0) | w_upper[0]);
    // Mantissa carry ripples into the exponent; max finite + carry lands exactly on infinity.
    assign w_rounded  = w_upper + {15'd0, w_round_up};

    always_comb begin
        w_result    = w_rounded;
        w_invalid   = 1'b0;
        w_overflow  = 1'b0;
        w_underflow = 1'b0;
        w_inexact   = 1'b0;
        if (w_is_nan) begin
            w_result  = 16'h7FC0;
            w_invalid = ~w_m[22];
        end else if (w_is_inf) begin
            w_result = {w_s, 8'hFF, 7'h00};
        end else if (w_is_zero) begin
            w_result = {w_s, 15'h0000};
        end else begin
            w_inexact   = (w_lower != 16'd0);
            w_overflow  = (w_rounded[14:7] == 8'hFF);
            w_underflow = (w_e == 8'h00) && (w_lower != 16'd0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_result    <= 16'h0000;
            r_invalid   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_inexact   <= 1'b0;
        end else begin
            r_result    <= w_result;
            r_invalid   <= w_invalid;
            r_overflow  <= w_overflow;
            r_underflow <= w_underflow;
            r_inexact   <= w_inexact;
        end
    end

    assign result    = r_result;
    assign invalid   = r_invalid;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign inexact   = r_inexact;

endmodule

// File: tb/tb_fp32_to_bf16_cvt.sv
// Scoreboard bench for fp32_to_bf16_cvt: directed vectors push expectations,
// a monitor pops and compares one cycle after each vector is captured.
module tb_fp32_to_bf16_cvt;

    logic        clk;
    logic        reset;
    logic [31:0] operand_a;
    logic [15:0] result;
    logic        invalid;
    logic        overflow;
    logic        underflow;
    logic        inexact;

    // flags packed as {invalid, overflow, underflow, inexact}
    typedef struct {
        logic [31:0] op;
        logic [15:0] res;
        logic [3:0]  flg;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    fp32_to_bf16_cvt dut (
        .clk       (clk),
        .reset     (reset),
        .operand_a (operand_a),
        .result    (result),
        .invalid   (invalid),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] op,
                         input logic [15:0] got_r, input logic [3:0] got_f,
                         input logic [15:0] exp_r, input logic [3:0] exp_f);
        n_checks++;
        if (got_r !== exp_r || got_f !== exp_f) begin
            n_errors++;
            $display("FAIL %s op=%08h: got result=%04h flags=%04b, expected result=%04h flags=%04b",
                     name, op, got_r, got_f, exp_r, exp_f);
        end
    endtask

    task automatic send(input logic [31:0] op, input logic [15:0] r, input logic [3:0] f);
        exp_t e;
        @(negedge clk);
        operand_a = op;
        e.op  = op;
        e.res = r;
        e.flg = f;
        exp_q.push_back(e);
    endtask

    // Monitor: output is valid one edge after each pushed vector.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("vector", e.op, result, {invalid, overflow, underflow, inexact}, e.res, e.flg);
            end
        end
    end

    initial begin
        int budget;
        reset     = 1'b0;
        operand_a = 32'h3F800000;
        repeat (2) @(negedge clk);
        check("reset_hold", operand_a, result, {invalid, overflow, underflow, inexact}, 16'h0000, 4'b0000);
        operand_a = 32'h7F800001;
        @(negedge clk);
        check("reset_hold_op", operand_a, result, {invalid, overflow, underflow, inexact}, 16'h0000, 4'b0000);
        operand_a = 32'h40490FDB;
        #2 reset = 1'b1;

        send(32'h40490FDB, 16'h4049, 4'b0001);
        send(32'h80000000, 16'h8000, 4'b0000);
        send(32'hFF800000, 16'hFF80, 4'b0000);
        send(32'hFFC00000, 16'h7FC0, 4'b0000);
        send(32'h7F800001, 16'h7FC0, 4'b1000);
        send(32'hFF800001, 16'h7FC0, 4'b1000);
        send(32'h7FFFFFFF, 16'h7FC0, 4'b0000);
        send(32'h7F7FFFFF, 16'h7F80, 4'b0101);
        send(32'hFF7FFFFF, 16'hFF80, 4'b0101);
        send(32'h7F7F8000, 16'h7F80, 4'b0101);
        send(32'h00800000, 16'h0080, 4'b0000);
        send(32'h007FFFFF, 16'h0080, 4'b0011);
        send(32'h807FFFFF, 16'h8080, 4'b0011);
        send(32'h00010000, 16'h0001, 4'b0000);
        send(32'h00008000, 16'h0000, 4'b0011);
        send(32'h3EAAAAAB, 16'h3EAB, 4'b0001);
        send(32'h3F808000, 16'h3F80, 4'b0001);
        send(32'h3F818000, 16'h3F82, 4'b0001);
        send(32'h3F80FFFF, 16'h3F81, 4'b0001);
        send(32'hC0490FDB, 16'hC049, 4'b0001);
        send(32'hBF800000, 16'hBF80, 4'b0000);
        send(32'h00000000, 16'h0000, 4'b0000);

        // Mid-stream reset: in-flight vector is discarded, outputs clear immediately.
        @(negedge clk);
        operand_a = 32'h7F7FFFFF;
        #2 reset = 1'b0;
        #1;
        check("async_reset", operand_a, result, {invalid, overflow, underflow, inexact}, 16'h0000, 4'b0000);
        @(negedge clk);
        check("reset_after_edge", operand_a, result, {invalid, overflow, underflow, inexact}, 16'h0000, 4'b0000);
        reset = 1'b1;

        send(32'h3F818000, 16'h3F82, 4'b0001);
        send(32'h7F800001, 16'h7FC0, 4'b1000);

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
